// File: rtl/mem_access_unit_if.sv
// Single-outstanding req/ack data bus between the MEM stage (master) and memory (slave).
// Byte enables are big-endian: sel[3] covers bits 31:24, which is byte address 0.
interface mem_access_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        sel;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (
        output req, we, addr, sel, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, sel, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM stage: runs loads/stores on a single-outstanding req/ack bus, stalls the pipeline until
// completion and registers the MEM/WB fields. Define MEM_ALIGN_EXC_EN for alignment exceptions.
module mem_access_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RADDR_W-1:0] mem_wd,
    input  logic               mem_wreg,
    input  logic [DATA_W-1:0]  mem_wdata,
    input  logic [3:0]         mem_op,
    input  logic [ADDR_W-1:0]  mem_addr,
    input  logic [DATA_W-1:0]  mem_sdata,
    input  logic               flush,
    mem_access_unit_if.master  bus,
    output logic               stallreq,
    output logic [RADDR_W-1:0] wb_wd,
    output logic               wb_wreg,
    output logic [DATA_W-1:0]  wb_wdata
`ifdef MEM_ALIGN_EXC_EN
    ,
    output logic               exc_adel,
    output logic               exc_ades
`endif
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    state_e            state_q, state_d;
    size_e             size;
    logic              is_load, is_store, is_mem, signed_ld;
    logic              misaligned;
    logic              issue, complete;
    logic              kill;
    logic [1:0]        byte_off;
    logic [3:0]        sel_d;
    logic [DATA_W-1:0] wdata_d;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_data;

    assign byte_off = mem_addr[1:0];
    assign is_mem   = is_load | is_store;

    // NOTE: every signal written in an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        signed_ld = 1'b0;
        size      = SZ_W;
        case (mem_op)
            OP_LB:  begin is_load = 1'b1; signed_ld = 1'b1; size = SZ_B; end
            OP_LBU: begin is_load = 1'b1; size = SZ_B; end
            OP_LH:  begin is_load = 1'b1; signed_ld = 1'b1; size = SZ_H; end
            OP_LHU: begin is_load = 1'b1; size = SZ_H; end
            OP_LW:  begin is_load = 1'b1; size = SZ_W; end
            OP_SB:  begin is_store = 1'b1; size = SZ_B; end
            OP_SH:  begin is_store = 1'b1; size = SZ_H; end
            OP_SW:  begin is_store = 1'b1; size = SZ_W; end
            default: ;
        endcase
    end

`ifdef MEM_ALIGN_EXC_EN
    assign misaligned = is_mem && (((size == SZ_H) && byte_off[0]) ||
                                   ((size == SZ_W) && (byte_off != 2'b00)));
`else
    // Without exceptions, low address bits beyond the access size are simply ignored.
    assign misaligned = 1'b0;
`endif

    assign issue    = (state_q == IDLE) && is_mem && !flush && !misaligned;
    assign complete = (state_q == WAIT) && bus.ack;

    always_comb begin
        state_d  = state_q;
        stallreq = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    stallreq = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                stallreq = !bus.ack;
                if (bus.ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Lane enables and lane-replicated store data; loads drive zero write data.
    always_comb begin
        sel_d   = 4'b0000;
        wdata_d = '0;
        case (size)
            SZ_B: begin
                sel_d   = 4'b1000 >> byte_off;
                wdata_d = {4{mem_sdata[7:0]}};
            end
            SZ_H: begin
                sel_d   = byte_off[1] ? 4'b0011 : 4'b1100;
                wdata_d = {2{mem_sdata[15:0]}};
            end
            default: begin
                sel_d   = 4'b1111;
                wdata_d = mem_sdata;
            end
        endcase
        if (!is_store) wdata_d = '0;
    end

    // Big-endian lane select: byte address b lives in lane (3-b).
    always_comb begin
        ld_byte = 8'h00;
        case (byte_off)
            2'd0: ld_byte = bus.rdata[31:24];
            2'd1: ld_byte = bus.rdata[23:16];
            2'd2: ld_byte = bus.rdata[15:8];
            2'd3: ld_byte = bus.rdata[7:0];
            default: ;
        endcase
        ld_half = byte_off[1] ? bus.rdata[15:0] : bus.rdata[31:16];
        case (size)
            SZ_B:    ld_data = signed_ld ? {{(DATA_W-8){ld_byte[7]}}, ld_byte}
                                         : {{(DATA_W-8){1'b0}}, ld_byte};
            SZ_H:    ld_data = signed_ld ? {{(DATA_W-16){ld_half[15]}}, ld_half}
                                         : {{(DATA_W-16){1'b0}}, ld_half};
            default: ld_data = bus.rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.req   <= 1'b0;
            bus.we    <= 1'b0;
            bus.addr  <= '0;
            bus.sel   <= 4'b0000;
            bus.wdata <= '0;
            kill      <= 1'b0;
            wb_wd     <= '0;
            wb_wreg   <= 1'b0;
            wb_wdata  <= '0;
        end else begin
            if (issue) begin
                bus.req   <= 1'b1;
                bus.we    <= is_store;
                bus.addr  <= {mem_addr[ADDR_W-1:2], 2'b00};
                bus.sel   <= sel_d;
                bus.wdata <= wdata_d;
            end else if (complete) begin
                bus.req <= 1'b0;
            end

            // The bus cannot be aborted, so a flush in WAIT only suppresses the write-back.
            if (state_q == WAIT && !bus.ack && flush) kill <= 1'b1;
            else if (state_q != WAIT || bus.ack)     kill <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (is_mem) begin
                        wb_wreg <= 1'b0;
                    end else begin
                        wb_wd    <= mem_wd;
                        wb_wreg  <= mem_wreg & ~flush;
                        wb_wdata <= mem_wdata;
                    end
                end
                WAIT: begin
                    if (bus.ack) begin
                        wb_wd   <= mem_wd;
                        wb_wreg <= mem_wreg & ~kill & ~flush;
                        if (is_load) wb_wdata <= ld_data;
                    end else begin
                        wb_wreg <= 1'b0;
                    end
                end
                default: wb_wreg <= 1'b0;
            endcase
        end
    end

`ifdef MEM_ALIGN_EXC_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exc_adel <= 1'b0;
            exc_ades <= 1'b0;
        end else begin
            exc_adel <= (state_q == IDLE) && misaligned && is_load && !flush;
            exc_ades <= (state_q == IDLE) && misaligned && is_store && !flush;
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected bus requests and write-backs,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_access_unit;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LBU  = 4'd2;
    localparam logic [3:0] OP_LH   = 4'd3;
    localparam logic [3:0] OP_LHU  = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SB   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic [4:0]  wd;
        logic [31:0] data;
    } wb_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_sdata;
    logic        flush;
    logic        stallreq;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
`ifdef MEM_ALIGN_EXC_EN
    logic        exc_adel;
    logic        exc_ades;
`endif

    mem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) bus_if ();

    mem_access_unit dut (
        .clk       (clk),
        .rst       (rst),
        .mem_wd    (mem_wd),
        .mem_wreg  (mem_wreg),
        .mem_wdata (mem_wdata),
        .mem_op    (mem_op),
        .mem_addr  (mem_addr),
        .mem_sdata (mem_sdata),
        .flush     (flush),
        .bus       (bus_if.master),
        .stallreq  (stallreq),
        .wb_wd     (wb_wd),
        .wb_wreg   (wb_wreg),
        .wb_wdata  (wb_wdata)
`ifdef MEM_ALIGN_EXC_EN
        ,
        .exc_adel  (exc_adel),
        .exc_ades  (exc_ades)
`endif
    );

    always #5 clk = ~clk;

    bus_exp_t bus_q[$];
    wb_exp_t  wb_q[$];
    int       n_cmp = 0;
    int       n_bad = 0;
    int       stall_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations when a request rises or a write-back is presented.
    initial begin : monitor
        logic     req_prev;
        bus_exp_t cap;
        bus_exp_t be;
        wb_exp_t  we;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (stallreq) stall_cnt++;
            if (bus_if.req && !req_prev) begin
                if (bus_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL bus_unexpected_req: addr 0x%08h with no access pending", bus_if.addr);
                end else begin
                    be = bus_q.pop_front();
                    check("bus_we",    {31'd0, bus_if.we}, {31'd0, be.we});
                    check("bus_addr",  bus_if.addr, be.addr);
                    check("bus_sel",   {28'd0, bus_if.sel}, {28'd0, be.sel});
                    if (be.we) check("bus_wdata", bus_if.wdata, be.wdata);
                end
                cap.we = bus_if.we; cap.addr = bus_if.addr;
                cap.sel = bus_if.sel; cap.wdata = bus_if.wdata;
            end else if (bus_if.req && req_prev) begin
                check("bus_hold_we",    {31'd0, bus_if.we}, {31'd0, cap.we});
                check("bus_hold_addr",  bus_if.addr, cap.addr);
                check("bus_hold_sel",   {28'd0, bus_if.sel}, {28'd0, cap.sel});
                check("bus_hold_wdata", bus_if.wdata, cap.wdata);
            end
            req_prev = bus_if.req;
            if (wb_wreg) begin
                if (wb_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL wb_unexpected_write: wd %0d data 0x%08h", wb_wd, wb_wdata);
                end else begin
                    we = wb_q.pop_front();
                    check("wb_wd",    {27'd0, wb_wd}, {27'd0, we.wd});
                    check("wb_wdata", wb_wdata, we.data);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic idle_inputs();
        mem_op = OP_NONE; mem_wreg = 1'b0; mem_wd = 5'd0; mem_wdata = 32'd0;
        mem_addr = 32'd0; mem_sdata = 32'd0; flush = 1'b0;
    endtask

    // Non-memory op held for one cycle; called at posedge+1.
    task automatic pass(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
        wb_exp_t w;
        int s0;
        if (wreg) begin
            w.wd = wd; w.data = wdata; wb_q.push_back(w);
        end
        s0 = stall_cnt;
        mem_op = OP_NONE; mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
        @(posedge clk); #1;
        check("pass_wb_wreg", {31'd0, wb_wreg}, {31'd0, wreg});
        idle_inputs();
        @(posedge clk); #1;
        check("pass_stall_cycles", s0 == stall_cnt ? 32'd0 : 32'd1, 32'd0);
    endtask

    // Memory op with ack after 'waits' idle WAIT cycles; flush pulsed in WAIT cycle flush_at (0 = none).
    task automatic do_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] wd, input logic wreg, input logic [31:0] rdata,
                          input int waits, input int flush_at,
                          input logic [31:0] e_addr, input logic [3:0] e_sel, input logic [31:0] e_wdata,
                          input logic e_write, input logic [31:0] e_data);
        bus_exp_t b;
        wb_exp_t  w;
        int s0;
        b.we = (op >= OP_SB); b.addr = e_addr; b.sel = e_sel; b.wdata = e_wdata;
        bus_q.push_back(b);
        if (e_write) begin
            w.wd = wd; w.data = e_data; wb_q.push_back(w);
        end
        s0 = stall_cnt;
        mem_op = op; mem_addr = addr; mem_sdata = sdata; mem_wd = wd; mem_wreg = wreg;
        mem_wdata = 32'h5555_AAAA; flush = 1'b0;
        @(posedge clk); #1;
        for (int i = 1; i <= waits + 1; i++) begin
            flush = (i == flush_at);
            if (i == waits + 1) begin
                bus_if.rdata = rdata;
                bus_if.ack   = 1'b1;
            end
            @(posedge clk); #1;
            flush = 1'b0;
            bus_if.ack = 1'b0;
            bus_if.rdata = 32'hDEAD_BEEF;
        end
        check("mem_wb_wreg", {31'd0, wb_wreg}, {31'd0, e_write});
        check("mem_req_dropped", {31'd0, bus_if.req}, 32'd0);
        idle_inputs();
        check("mem_stall_cycles", stall_cnt - s0, waits + 1);
    endtask

    initial begin : stimulus
        rst = 1'b0;
        idle_inputs();
        bus_if.ack = 1'b0;
        bus_if.rdata = 32'd0;
        #12;
        check("rst_bus_req",  {31'd0, bus_if.req}, 32'd0);
        check("rst_bus_sel",  {28'd0, bus_if.sel}, 32'd0);
        check("rst_bus_addr", bus_if.addr, 32'd0);
        check("rst_wb_wreg",  {31'd0, wb_wreg}, 32'd0);
        check("rst_wb_wd",    {27'd0, wb_wd}, 32'd0);
        check("rst_wb_wdata", wb_wdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of a WAIT abandons the access.
        begin
            bus_exp_t b;
            b.we = 1'b0; b.addr = 32'h40; b.sel = 4'b1111; b.wdata = 32'd0;
            bus_q.push_back(b);
            mem_op = OP_LW; mem_addr = 32'h40; mem_wd = 5'd4; mem_wreg = 1'b1;
            @(posedge clk); #1;
            @(posedge clk); #1;
            check("midwait_req_before_rst", {31'd0, bus_if.req}, 32'd1);
            rst = 1'b0;
            idle_inputs();
            #1;
            check("midwait_rst_req", {31'd0, bus_if.req}, 32'd0);
            check("midwait_rst_wreg", {31'd0, wb_wreg}, 32'd0);
            check("midwait_rst_idle_stall", {31'd0, stallreq}, 32'd0);
            @(posedge clk); #1;
            rst = 1'b1;
            bus_if.ack = 1'b1;
            pass(5'd3, 1'b1, 32'hCAFE_0001);
            bus_if.ack = 1'b0;
            check("late_ack_req", {31'd0, bus_if.req}, 32'd0);
        end

        // Pass-through.
        pass(5'd5, 1'b1, 32'h1234_5678);
        pass(5'd6, 1'b0, 32'h0BAD_0BAD);

        // Loads.
        do_mem(OP_LB,  32'h101, 32'd0, 5'd7,  1'b1, 32'h11F2_3344, 3, 0, 32'h100, 4'b0100, 32'd0, 1'b1, 32'hFFFF_FFF2);
        do_mem(OP_LBU, 32'h101, 32'd0, 5'd8,  1'b1, 32'h11F2_3344, 1, 0, 32'h100, 4'b0100, 32'd0, 1'b1, 32'h0000_00F2);
        do_mem(OP_LB,  32'h103, 32'd0, 5'd11, 1'b1, 32'h11F2_337F, 0, 0, 32'h100, 4'b0001, 32'd0, 1'b1, 32'h0000_007F);
        do_mem(OP_LH,  32'h102, 32'd0, 5'd12, 1'b1, 32'h1234_8001, 2, 0, 32'h100, 4'b0011, 32'd0, 1'b1, 32'hFFFF_8001);
        do_mem(OP_LHU, 32'h100, 32'd0, 5'd13, 1'b1, 32'h8001_1234, 1, 0, 32'h100, 4'b1100, 32'd0, 1'b1, 32'h0000_8001);
        do_mem(OP_LW,  32'h204, 32'd0, 5'd14, 1'b1, 32'hA5A5_0F0F, 0, 0, 32'h204, 4'b1111, 32'd0, 1'b1, 32'hA5A5_0F0F);

        // Stores.
        do_mem(OP_SH, 32'h22, 32'h0000_ABCD, 5'd0, 1'b0, 32'd0, 2, 0, 32'h20, 4'b0011, 32'hABCD_ABCD, 1'b0, 32'd0);
        do_mem(OP_SB, 32'h31, 32'h0000_005A, 5'd0, 1'b0, 32'd0, 1, 0, 32'h30, 4'b0100, 32'h5A5A_5A5A, 1'b0, 32'd0);
        do_mem(OP_SW, 32'h40, 32'h0123_4567, 5'd0, 1'b0, 32'd0, 0, 0, 32'h40, 4'b1111, 32'h0123_4567, 1'b0, 32'd0);

        // Flush in the second WAIT cycle: access completes, nothing written back.
        do_mem(OP_LW, 32'h80, 32'd0, 5'd9, 1'b1, 32'hFFFF_0000, 4, 2, 32'h80, 4'b1111, 32'd0, 1'b0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("post_flush_req", {31'd0, bus_if.req}, 32'd0);
        end
        do_mem(OP_LW, 32'h84, 32'd0, 5'd10, 1'b1, 32'h1357_9BDF, 1, 0, 32'h84, 4'b1111, 32'd0, 1'b1, 32'h1357_9BDF);

        // Flush of a memory op still in IDLE: no access.
        mem_op = OP_LW; mem_addr = 32'h88; mem_wd = 5'd2; mem_wreg = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        check("idle_flush_req", {31'd0, bus_if.req}, 32'd0);
        check("idle_flush_wreg", {31'd0, wb_wreg}, 32'd0);
        idle_inputs();
        @(posedge clk); #1;

`ifdef MEM_ALIGN_EXC_EN
        mem_op = OP_LW; mem_addr = 32'h103; mem_wd = 5'd16; mem_wreg = 1'b1;
        #1;
        check("adel_stall", {31'd0, stallreq}, 32'd0);
        @(posedge clk); #1;
        check("adel_pulse", {31'd0, exc_adel}, 32'd1);
        check("adel_no_ades", {31'd0, exc_ades}, 32'd0);
        check("adel_req", {31'd0, bus_if.req}, 32'd0);
        check("adel_wreg", {31'd0, wb_wreg}, 32'd0);
        idle_inputs();
        @(posedge clk); #1;
        check("adel_clear", {31'd0, exc_adel}, 32'd0);
        mem_op = OP_SH; mem_addr = 32'h21; mem_sdata = 32'h1111;
        #1;
        check("ades_stall", {31'd0, stallreq}, 32'd0);
        @(posedge clk); #1;
        check("ades_pulse", {31'd0, exc_ades}, 32'd1);
        check("ades_req", {31'd0, bus_if.req}, 32'd0);
        idle_inputs();
        @(posedge clk); #1;
        check("ades_clear", {31'd0, exc_ades}, 32'd0);
`else
        // Misaligned addresses truncate to the natural size.
        do_mem(OP_LW, 32'h103, 32'd0, 5'd15, 1'b1, 32'h0BAD_F00D, 1, 0, 32'h100, 4'b1111, 32'd0, 1'b1, 32'h0BAD_F00D);
        do_mem(OP_LH, 32'h101, 32'd0, 5'd17, 1'b1, 32'h7FFE_1111, 0, 0, 32'h100, 4'b1100, 32'd0, 1'b1, 32'h0000_7FFE);
`endif

        pass(5'd31, 1'b1, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("bus_q_drained", bus_q.size(), 32'd0);
        check("wb_q_drained", wb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
